// File: rtl/riscv_mc.sv
// riscv_mc: multi-cycle RV32I/RV32E core with ready/ack instruction and data buses.
// One instruction at a time: FETCH, DECODE, EXEC, optional MEM, WB; traps park in HALT.
module riscv_mc #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] pc_out
);
    localparam int RW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]  state;
    logic [31:0] pc, ir, rs1_v, rs2_v, imm, res, npc;
    logic [1:0]  ea_lo;
    logic [31:0] regs [NREGS];

    logic [6:0] opc, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opc = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7  = ir[31:25];

    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    assign is_lui   = opc == 7'b0110111;
    assign is_auipc = opc == 7'b0010111;
    assign is_jal   = opc == 7'b1101111;
    assign is_jalr  = opc == 7'b1100111;
    assign is_br    = opc == 7'b1100011;
    assign is_ld    = opc == 7'b0000011;
    assign is_st    = opc == 7'b0100011;
    assign is_opi   = opc == 7'b0010011;
    assign is_op    = opc == 7'b0110011;

    logic legal, bad_reg, use_rd, use_rs1, use_rs2;
    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            is_lui, is_auipc, is_jal: legal = 1'b1;
            is_jalr: legal = f3 == 3'd0;
            is_br:   legal = f3[2:1] != 2'b01;
            is_ld:   legal = f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
            is_st:   legal = !f3[2] && f3[1:0] != 2'b11;
            is_opi:  legal = (f3 == 3'd1) ? f7 == 7'h00 :
                             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            is_op:   legal = f7 == 7'h00 ||
                             (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            default: legal = 1'b0;
        endcase
    end

    // Only register fields the format actually uses count against RV32E.
    assign use_rd  = !(is_br || is_st);
    assign use_rs1 = !(is_lui || is_auipc || is_jal);
    assign use_rs2 = is_br || is_st || is_op;
    assign bad_reg = (use_rd  && {1'b0, rd}  >= NR) ||
                     (use_rs1 && {1'b0, rs1} >= NR) ||
                     (use_rs2 && {1'b0, rs2} >= NR);

    logic [31:0] imm_d;
    always_comb begin
        imm_d = '0;
        unique case (1'b1)
            is_lui, is_auipc: imm_d = {ir[31:12], 12'b0};
            is_jal: imm_d = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            is_br:  imm_d = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            is_st:  imm_d = {{21{ir[31]}}, ir[30:25], ir[11:7]};
            default: imm_d = {{21{ir[31]}}, ir[30:20]};
        endcase
    end

    logic [31:0] op_b, alu, sra_v, pc4, target, ea, exec_res;
    logic        taken, jump, mis_tgt, mis_ea;
    assign op_b  = is_op ? rs2_v : imm;
    assign sra_v = $unsigned($signed(rs1_v) >>> op_b[4:0]);

    always_comb begin
        alu = '0;
        case (f3)
            3'd0: alu = (is_op && f7[5]) ? rs1_v - op_b : rs1_v + op_b;
            3'd1: alu = rs1_v << op_b[4:0];
            3'd2: alu = {31'b0, $signed(rs1_v) < $signed(op_b)};
            3'd3: alu = {31'b0, rs1_v < op_b};
            3'd4: alu = rs1_v ^ op_b;
            3'd5: alu = f7[5] ? sra_v : rs1_v >> op_b[4:0];
            3'd6: alu = rs1_v | op_b;
            default: alu = rs1_v & op_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'd0: taken = rs1_v == rs2_v;
            3'd1: taken = rs1_v != rs2_v;
            3'd4: taken = $signed(rs1_v) < $signed(rs2_v);
            3'd5: taken = $signed(rs1_v) >= $signed(rs2_v);
            3'd6: taken = rs1_v < rs2_v;
            3'd7: taken = rs1_v >= rs2_v;
            default: taken = 1'b0;
        endcase
    end

    assign pc4     = pc + 32'd4;
    assign ea      = rs1_v + imm;
    assign target  = is_jalr ? (ea & ~32'd1) : pc + imm;
    assign jump    = is_jal || is_jalr || (is_br && taken);
    assign mis_tgt = jump && target[1:0] != 2'b00;
    assign mis_ea  = (f3[1:0] == 2'b01 && ea[0]) ||
                     (f3[1:0] == 2'b10 && ea[1:0] != 2'b00);

    always_comb begin
        exec_res = alu;
        unique case (1'b1)
            is_lui:          exec_res = imm;
            is_auipc:        exec_res = pc + imm;
            is_jal, is_jalr: exec_res = pc4;
            default:         exec_res = alu;
        endcase
    end

    logic [3:0]  be_d;
    logic [31:0] wdata_d, lane, ld_val;
    always_comb begin
        case (f3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ea[1:0];
                wdata_d = {4{rs2_v[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {ea[1], 1'b0};
                wdata_d = {2{rs2_v[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = rs2_v;
            end
        endcase
    end

    assign lane = dmem_rdata >> {ea_lo, 3'b000};
    always_comb begin
        case (f3)
            3'd0: ld_val = {{24{lane[7]}}, lane[7:0]};
            3'd1: ld_val = {{16{lane[15]}}, lane[15:0]};
            3'd4: ld_val = {24'b0, lane[7:0]};
            3'd5: ld_val = {16'b0, lane[15:0]};
            default: ld_val = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            rs1_v      <= '0;
            rs2_v      <= '0;
            imm        <= '0;
            res        <= '0;
            npc        <= '0;
            ea_lo      <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            trap_cause <= 2'd0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!legal || bad_reg) begin
                        trap_cause <= 2'd1;
                        state      <= S_HALT;
                    end else begin
                        rs1_v <= regs[rs1[RW-1:0]];
                        rs2_v <= regs[rs2[RW-1:0]];
                        imm   <= imm_d;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    npc <= jump ? target : pc4;
                    res <= exec_res;
                    if (mis_tgt) begin
                        trap_cause <= 2'd3;
                        state      <= S_HALT;
                    end else if ((is_ld || is_st) && mis_ea) begin
                        trap_cause <= 2'd2;
                        state      <= S_HALT;
                    end else if (is_ld || is_st) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_st;
                        dmem_addr  <= {ea[31:2], 2'b00};
                        dmem_be    <= be_d;
                        dmem_wdata <= wdata_d;
                        ea_lo      <= ea[1:0];
                        state      <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        res      <= ld_val;
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (use_rd && rd != 5'd0) regs[rd[RW-1:0]] <= res;
                    // Next fetch request goes out together with the new PC.
                    pc       <= npc;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign halted    = state == S_HALT;
endmodule

// File: doc/riscv_mc.md
# riscv_mc

Parametrised multi-cycle RV32I integer core and successor to the single-ROM/single-RAM sequencer core. It adds the full ALU set (OP, OP_IMM), byte-addressed fetch with PC+4, stores with byte enables, and separate ready/ack instruction and data buses with arbitrary wait states. It also adds configurable register-file depth (RV32I/RV32E) and a trap/halt state for illegal or misaligned operations. It sits between the program ROM, the data RAM/GPIO decoder and the board top.

## Interface
- `NREGS`, 32: architectural registers, 32 (RV32I) or 16 (RV32E).
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  32  byte address of fetch (= PC).
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `imem_ack`  in  1  fetch complete.
- `dmem_req`  out  1  data request; held until `dmem_ack`.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  32  word-aligned byte address (bits [1:0] = 0).
- `dmem_be`  out  4  byte enables, bit n = byte lane n.
- `dmem_wdata`  out  32  store data, replicated across lanes.
- `dmem_rdata`  in  32  load data, valid when `dmem_ack`=1.
- `dmem_ack`  in  1  data access complete.
- `halted`  out  1  core is in HALT.
- `trap_cause`  out  2  0 none, 1 illegal instruction, 2 misaligned data, 3 misaligned jump/branch target.
- `pc_out`  out  32  current PC (debug/GPIO).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encode as a one-hot or binary state register, never a shift chain.
- FETCH: assert `imem_req` with `imem_addr`=PC. On `imem_ack`, latch `imem_rdata` into IR and go to DECODE.
- DECODE: read rs1 and rs2, form the immediate (I/S/B/U/J, sign-extended) and check legality. An illegal instruction goes to HALT with cause 1.
- Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP. Anything else is illegal, including FENCE/SYSTEM and any unlisted funct3/funct7 combination.
- With NREGS=16, any rd/rs1/rs2 ≥ 16 is illegal.
- EXEC: the ALU computes the result or effective address. Branch compares: BEQ, BNE, BLT/BGE signed, BLTU/BGEU unsigned. BGE and BGEU are ≥.
- Shifts use shamt = operand[4:0]. SRA/SRAI are arithmetic.
- A taken branch, JAL or JALR whose target has bit1 or bit0 set goes to HALT with cause 3. JALR clears bit0 of the target before this check.
- A LOAD/STORE with a misaligned address (half: addr[0]; word: addr[1:0]≠0) goes to HALT with cause 2 and issues no bus request.
- Otherwise LOAD/STORE go to MEM and all other instructions go to WB.
- MEM: assert `dmem_req` until `dmem_ack`. The address is EA with [1:0] cleared.
- Store byte enables: SB 4'b0001 shifted by EA[1:0]; SH 4'b0011 shifted by EA[1]×2; SW 4'b1111.
- Store data: SB = rs2[7:0]×4, SH = rs2[15:0]×2, SW = rs2.
- Loads extract the lane by EA[1:0]: LB/LH sign-extend, LBU/LHU zero-extend.
- The load `dmem_be` is the same pattern as the store (informational).
- WB:
  - Write rd unless rd=0; x0 always reads 0.
  - Link value for JAL/JALR is PC+4.
  - Next PC is the target for JAL, JALR and taken branches, otherwise PC+4.
  - Return to FETCH.
- HALT: terminal. All request outputs are 0 and PC is frozen. Only reset leaves HALT.
- All arithmetic is 32-bit modulo 2^32. PC+4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset (async assert, sync deassert handled at top):
  - State = FETCH, PC = `RESET_PC`, `imem_req`=0, `dmem_req`=0, `dmem_we`=0, `dmem_be`=0, `halted`=0, `trap_cause`=0, `pc_out`=`RESET_PC`, all registers 0.
- `imem_req` rises the first cycle after reset release.
- Request outputs are registered. Req/addr stay stable while waiting for ack.
- Ack is sampled on the clock edge. Ack while req=0 is ignored.
- Minimum ack latency is 1 cycle after req is high, with a zero-wait memory that acks in the first cycle of req.
- The req deasserts in the cycle after the ack is sampled.
- Zero-wait latency: 4 cycles per ALU/jump/branch instruction (FETCH, DECODE, EXEC, WB) and 5 per load/store. Each ack wait cycle adds 1.
- Reset mid-request drops req immediately (async). No partial register write occurs.
- `halted` and `trap_cause` assert on the cycle HALT is entered and hold.

## Test plan
- Zero-wait ROM, `addi x1,x0,5; addi x2,x1,-7; add x3,x1,x2` → x1=5, x2=0xFFFF_FFFE, x3=3; PC=12 after 12 cycles.
- `lui x5,0x12345; sb x5,1(x0)` with RAM ack after 3 waits → `dmem_addr`=0, `dmem_be`=4'b0010, `dmem_wdata`=32'h0000_0000 (x5[7:0]=0); req held exactly 4 cycles.
- RAM word 0x8 = 32'h80FF_7F01: `lb` at 0xB → 0xFFFF_FF80; `lbu` at 0xB → 0x80; `lh` at 0xA → 0xFFFF_80FF; `lhu` at 0x8 → 0x7F01.
- BGE with x1=x2=−1 is taken; BLTU with x1=1, x2=0xFFFF_FFFF is taken. JAL x1,+8 at PC 0x10 → x1=0x14, PC=0x18.
- Illegal word 32'h0000_0000 → `halted`=1, `trap_cause`=1, no further `imem_req`. `lw` at 0x2 → cause 2, no `dmem_req`. NREGS=16 with `addi x17,...` → cause 1.
- Assert `rst_n`=0 mid-MEM wait → all outputs at reset values within the same cycle; the refetch after release is at `RESET_PC`.
